mac_seq32: RTL

- Sequential 16x16 shift-add multiply-accumulate engine for the GPU/DSP multiply path.
- Sits directly upstream of the 32-bit full adder stage. Each cycle it drives one partial product plus the running accumulator into the adder's a/b/ci inputs, then registers the sum and co32.
- One result per 17 cycles. The accumulator persists between operations to support multiply-accumulate chains.

---
 rtl/mac_seq32_pkg.sv | 12 +
 rtl/mac_seq32_fa32.sv | 12 +
 rtl/mac_seq32.sv | 107 ++++++++++
 3 files changed

// File: rtl/mac_seq32_pkg.sv
// Shared constants and state type for the mac_seq32 shift-add multiply-accumulate engine.
package mac_seq32_pkg;
    localparam int unsigned STEPS = 16;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned CNT_W = $clog2(STEPS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mac_seq32_fa32.sv
// 32-bit full adder used as the add stage of mac_seq32.
module mac_seq32_fa32
    import mac_seq32_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             ci,
    output logic [ACC_W-1:0] sum,
    output logic             co32
);
    assign {co32, sum} = {1'b0, a} + {1'b0, b} + (ACC_W + 1)'(ci);
endmodule

// File: rtl/mac_seq32.sv
// Sequential 16x16 shift-add MAC: one partial product per cycle into the full adder.
// Optional early termination for unsigned operands: define MAC_EARLY_TERM_EN.
module mac_seq32
    import mac_seq32_pkg::*;
(
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic             start,
    input  logic             acc_en,
    input  logic             sgn,
    input  logic [STEPS-1:0] opa,
    input  logic [STEPS-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [STEPS-1:0] opa_reg;
    logic [STEPS-1:0] opb_reg;
    logic             sgn_reg;
    logic [ACC_W-1:0] acc;

    logic [ACC_W-1:0] opb_ext;
    logic [ACC_W-1:0] pp;
    logic             neg_step;
    logic [ACC_W-1:0] add_b;
    logic [ACC_W-1:0] sum;
    logic             co32;
    logic             last_step;

    always_comb begin
        opb_ext  = sgn_reg ? {{(ACC_W-STEPS){opb_reg[STEPS-1]}}, opb_reg}
                           : {{(ACC_W-STEPS){1'b0}}, opb_reg};
        pp       = opa_reg[cnt] ? (opb_ext << cnt) : '0;
        // Signed MSB carries negative weight: subtract via ~pp + 1.
        neg_step = sgn_reg && (cnt == CNT_W'(STEPS - 1)) && opa_reg[STEPS-1];
        add_b    = neg_step ? ~pp : pp;
    end

    always_comb begin
        last_step = (cnt == CNT_W'(STEPS - 1));
`ifdef MAC_EARLY_TERM_EN
        if (!sgn_reg && (((opa_reg >> cnt) >> 1) == '0))
            last_step = 1'b1;
`endif
    end

    mac_seq32_fa32 u_add (
        .a    (acc),
        .b    (add_b),
        .ci   (neg_step),
        .sum  (sum),
        .co32 (co32)
    );

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            opa_reg <= '0;
            opb_reg <= '0;
            sgn_reg <= 1'b0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        opa_reg <= opa;
                        opb_reg <= opb;
                        sgn_reg <= sgn;
                        cnt     <= '0;
                        ovf     <= 1'b0;
                        if (!acc_en)
                            acc <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                    if (!sgn_reg && co32)
                        ovf <= 1'b1;
                    if (last_step) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign result = acc;
endmodule
